sync_fifo_flags: RTL

- Single-clock, parametrised FIFO; successor to the dual-clock FIFO for same-domain buffering.
- Adds occupancy count, programmable almost-full/almost-empty flags, and separate overflow/underflow error pulses.
- Supports simultaneous push/pop at the full boundary.
- Sits between a producer and a consumer stage in the same clock domain.

---
 rtl/sync_fifo_flags.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
// Single-clock FIFO with occupancy count, programmable almost-full and
// almost-empty flags, and one-cycle overflow/underflow error pulses.
// A push and a pop in the same cycle are both accepted when the FIFO is full.
//
// Optional build macro:
//   SYNC_FIFO_FWFT_EN  first-word-fall-through read port. rdata_o shows the
//                      head entry whenever the FIFO is not empty, and rd_en_i
//                      pops that word. When the macro is undefined, a pop loads
//                      the head word into rdata_o, which is valid one cycle
//                      later.
//
// Ports:
//   clk_i           clock, all logic on the rising edge
//   rst_i           synchronous active-high reset
//   wdata_i         write data
//   wr_en_i         push request
//   rd_en_i         pop request
//   rdata_o         read data
//   rvalid_o        rdata_o holds a popped word (FWFT: the head word is valid)
//   full_o          count == DEPTH
//   empty_o         count == 0
//   almost_full_o   count >= AFULL_THRESH
//   almost_empty_o  count <= AEMPTY_THRESH
//   count_o         occupancy, 0..DEPTH
//   overflow_o      one-cycle pulse after a rejected push
//   underflow_o     one-cycle pulse after a rejected pop

module sync_fifo_flags #(
    parameter int WIDTH         = 4,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  rvalid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH + 1)'(1);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] count_q;
    logic [ADDR_WIDTH:0] count_nxt;
    logic                push_acc;
    logic                pop_acc;

    // A pop frees a slot in the same cycle, so a push is allowed into a full
    // FIFO when a pop goes with it. A pop is never allowed from an empty FIFO,
    // even with a simultaneous push.
    always_comb begin
        pop_acc   = rd_en_i && !empty_o;
        push_acc  = wr_en_i && (!full_o || pop_acc);
        count_nxt = count_q;
        if (push_acc && !pop_acc) begin
            count_nxt = count_q + ONE_C;
        end else if (pop_acc && !push_acc) begin
            count_nxt = count_q - ONE_C;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + ONE_C;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + ONE_C;
            end
            count_q        <= count_nxt;
            // Flags are registered from the next count, so they change in the
            // same cycle as count_o.
            full_o         <= (count_nxt == DEPTH_C);
            empty_o        <= (count_nxt == '0);
            almost_full_o  <= (count_nxt >= AFULL_C);
            almost_empty_o <= (count_nxt <= AEMPTY_C);
            overflow_o     <= wr_en_i && !push_acc;
            underflow_o    <= rd_en_i && !pop_acc;
        end
    end

    assign count_o = count_q;

    // Storage is not reset. The pointers alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wdata_i;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // The head entry falls through combinationally. The read data is forced to
    // zero while empty, so no stale storage is ever shown.
    assign rdata_o  = empty_o ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign rvalid_o = !empty_o;
`else
    // On a simultaneous push and pop at full, both pointers address the same
    // entry. The non-blocking read still returns the old (oldest) word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
        end else begin
            rvalid_o <= pop_acc;
            if (pop_acc) begin
                rdata_o <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end
`endif

endmodule
